// File: rtl/mod_exp_ctrl_pkg.sv
// mod_exp_ctrl_pkg: shared defaults and FSM state encoding for the modular exponentiation controller
package mod_exp_ctrl_pkg;
  localparam int DEF_WIDTH = 256;
  localparam int DEF_EXP_BITS = 256;
  localparam int DEF_TIMEOUT = 16;
  typedef enum logic [2:0] {IDLE, SCAN, SQ_REQ, SQ_WAIT, ML_REQ, ML_WAIT, FIN, ERR} state_t;
endpackage

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: left-to-right square-and-multiply base^exponent mod p over a start/done multiplier handshake
module mod_exp_ctrl import mod_exp_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXP_BITS = DEF_EXP_BITS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [EXP_BITS-1:0] exponent,
  input  logic [WIDTH-1:0]    p,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [WIDTH-1:0]    result,
  output logic                mul_start,
  output logic [WIDTH-1:0]    mul_a,
  output logic [WIDTH-1:0]    mul_b,
  output logic [WIDTH-1:0]    mul_p,
  input  logic [WIDTH-1:0]    mul_product,
  input  logic                mul_done
);
  localparam int IW = EXP_BITS > 1 ? $clog2(EXP_BITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [WIDTH-1:0] acc, base_r;
  logic [EXP_BITS-1:0] exp_r;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic seen_one, bit_cur, last;
  assign bit_cur = exp_r[idx];
  assign last = idx == '0;
  // timer is loaded with 1 in the request cycle so it counts cycles since mul_start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      result <= '0;
      mul_start <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      mul_p <= '0;
      acc <= '0;
      base_r <= '0;
      exp_r <= '0;
      idx <= '0;
      timer <= '0;
      seen_one <= 1'b0;
    end else begin
      done <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            base_r <= base;
            exp_r <= exponent;
            mul_p <= p;
            idx <= IW'(EXP_BITS - 1);
            acc <= WIDTH'(1);
            seen_one <= 1'b0;
            busy <= 1'b1;
            state <= SCAN;
          end
        SCAN:
          if (seen_one) begin
            mul_start <= 1'b1;
            mul_a <= acc;
            mul_b <= acc;
            state <= SQ_REQ;
          end else begin
            if (bit_cur) begin
              acc <= base_r;
              seen_one <= 1'b1;
            end
            if (last) begin
              done <= 1'b1;
              error <= 1'b0;
              result <= bit_cur ? base_r : acc;
              state <= FIN;
            end else
              idx <= idx - 1'b1;
          end
        SQ_REQ, ML_REQ: begin
          timer <= TW'(1);
          state <= state == SQ_REQ ? SQ_WAIT : ML_WAIT;
        end
        SQ_WAIT, ML_WAIT:
          if (mul_done) begin
            acc <= mul_product;
            if (state == SQ_WAIT && bit_cur) begin
              mul_start <= 1'b1;
              mul_a <= mul_product;
              mul_b <= base_r;
              state <= ML_REQ;
            end else if (last) begin
              done <= 1'b1;
              error <= 1'b0;
              result <= mul_product;
              state <= FIN;
            end else begin
              idx <= idx - 1'b1;
              state <= SCAN;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            done <= 1'b1;
            error <= 1'b1;
            result <= '0;
            state <= ERR;
          end else
            timer <= timer + 1'b1;
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb_mod_exp_ctrl: scoreboard bench with a behavioural modular-multiply responder and a pow-mod reference model
module tb_mod_exp_ctrl;
  localparam int W = 64;
  localparam int W2 = 2 * W;
  localparam int EB = 16;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n, start, stub, spur_done, resp_done;
  logic [W-1:0] base_i, p_i;
  logic [EB-1:0] exp_i;
  logic busy, done, error, mul_start, mul_done;
  logic [W-1:0] result, mul_a, mul_b, mul_p, mul_product;
  typedef struct {logic [W-1:0] res; logic err; int nreq; int lat;} exp_t;
  exp_t expq[$];
  int checks = 0;
  int fails = 0;
  assign mul_done = resp_done | spur_done;
  always #5 clk = ~clk;

  mod_exp_ctrl #(.WIDTH(W), .EXP_BITS(EB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base_i), .exponent(exp_i), .p(p_i),
    .busy(busy), .done(done), .error(error), .result(result),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [W-1:0] mpow(input logic [W-1:0] b, input logic [EB-1:0] e, input logic [W-1:0] m);
    logic [W2-1:0] r, x;
    r = 1;
    x = W2'(b);
    for (int i = 0; i < EB; i++) begin
      if (e[i]) r = (r * x) % W2'(m);
      x = (x * x) % W2'(m);
    end
    return e == 0 ? W'(1) : W'(r);
  endfunction

  function automatic int nreq_of(input logic [EB-1:0] e);
    int hi = 0;
    if (e == 0) return 0;
    for (int i = 0; i < EB; i++) if (e[i]) hi = i;
    return hi + $countones(e) - 1;
  endfunction

  task automatic issue(input logic [W-1:0] b, input logic [EB-1:0] e, input logic [W-1:0] m);
    exp_t x;
    x.res = mpow(b, e, m);
    x.err = 1'b0;
    x.nreq = nreq_of(e);
    x.lat = -1;
    expq.push_back(x);
    base_i = b;
    exp_i = e;
    p_i = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input bit drop);
    bit got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      got = done;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL %s: no done within 2000 cycles", nm);
    end
    if (drop) start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [W-1:0] b, input logic [EB-1:0] e, input logic [W-1:0] m);
    issue(b, e, m);
    wait_done("op_done", 1'b1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_flags"}, W'({busy, done, error, mul_start}), '0);
    chk({nm, "_result"}, result, '0);
    chk({nm, "_mul_a"}, mul_a, '0);
    chk({nm, "_mul_b"}, mul_b, '0);
    chk({nm, "_mul_p"}, mul_p, '0);
  endtask

  initial begin : responder
    logic [W-1:0] a, b, m;
    int lat;
    bit alive;
    resp_done = 1'b0;
    mul_product = '0;
    forever begin
      @(posedge clk); #1;
      resp_done = 1'b0;
      if (rst_n && mul_start && !stub) begin
        a = mul_a;
        b = mul_b;
        m = mul_p;
        chk("mul_p_captured", m, p_i);
        lat = $urandom_range(1, 6);
        alive = 1'b1;
        for (int i = 0; i < lat && alive; i++) begin
          @(posedge clk); #1;
          if (!rst_n) alive = 1'b0;
          else begin
            chk("mul_a_stable", mul_a, a);
            chk("mul_b_stable", mul_b, b);
            chk("mul_p_stable", mul_p, m);
          end
        end
        if (alive) begin
          mul_product = W'((W2'(a) * W2'(b)) % W2'(m));
          resp_done = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    int reqs, first, cyc;
    bit pd, ps;
    exp_t e;
    reqs = 0;
    first = 0;
    cyc = 0;
    pd = 1'b0;
    ps = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        reqs = 0;
        pd = 1'b0;
        ps = 1'b0;
      end else begin
        if (mul_start) begin
          chk("mul_start_gap", W'(ps), '0);
          if (reqs == 0) first = cyc;
          reqs++;
        end
        if (done) begin
          chk("done_width", W'(pd), '0);
          if (expq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no done");
          end else begin
            e = expq.pop_front();
            chk("result", result, e.res);
            chk("error", W'(error), W'(e.err));
            chk("req_count", W'(reqs), W'(e.nreq));
            chk("busy_with_done", W'(busy), W'(1));
            if (e.lat >= 0) chk("timeout_latency", W'(cyc - first), W'(e.lat));
          end
          reqs = 0;
        end
        pd = done;
        ps = mul_start;
      end
    end
  end

  initial begin
    exp_t x;
    int n;
    logic [W-1:0] rb, rp;
    rst_n = 1'b0;
    start = 1'b0;
    stub = 1'b0;
    spur_done = 1'b0;
    base_i = '0;
    exp_i = '0;
    p_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(3, 5, 7);
    run(2, 10, 1000);
    run(4, 0, 7);
    run(6, 1, 7);
    run(5, 16'h8000, 1_000_003);
    run(7, 16'hFFFF, 65_537);
    for (int k = 0; k < 20; k++) begin
      rp = {16'($urandom_range(0, 65535)), $urandom};
      if (rp < 2) rp = 2;
      rb = {$urandom, $urandom} % rp;
      run(rb, 16'($urandom), rp);
    end
    stub = 1'b1;
    x = '{res: '0, err: 1'b1, nreq: 1, lat: TO};
    expq.push_back(x);
    base_i = 5;
    exp_i = 2;
    p_i = 11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("timeout_done", 1'b1);
    stub = 1'b0;
    issue(3, 5, 7);
    x = expq[0];
    expq.push_back(x);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    wait_done("held_first", 1'b0);
    wait_done("held_second", 1'b1);
    repeat (4) @(posedge clk);
    #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_idle", W'({busy, done, mul_start}), '0);
    issue(2, 10, 1000);
    n = 0;
    for (int i = 0; i < 500 && n < 2; i++) begin
      @(posedge clk); #1;
      if (mul_start) n++;
    end
    chk("second_request_seen", W'(n), W'(2));
    @(posedge clk); #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    check_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(2, 10, 1000);
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", W'(expq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
